// File: rtl/serial_adder_pkg.sv
// Shared constants and helpers for the multi-lane bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned WORD_LEN_DEF   = 8;
  localparam int unsigned LANES_DEF      = 2;
  localparam bit          SIGNED_OVF_DEF = 1'b0;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = $clog2(n);
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_add_lane.sv
// One bit-serial adder lane: carry flop plus registered sum and overflow bits.
module serial_add_lane
  import serial_adder_pkg::*;
#(
  parameter bit SIGNED_OVF = SIGNED_OVF_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  logic a,
  input  logic b_eff,
  input  logic first,
  input  logic last,
  input  logic sub_q,
  output logic sum_o,
  output logic ovf_o
);

  logic carry_q;
  logic cin_c;
  logic cout_c;
  logic sum_c;
  logic ovf_c;

  // Full-adder slice; carry-in comes from the word's mode on bit 0.
  always_comb begin
    cin_c  = first ? sub_q : carry_q;
    sum_c  = a ^ b_eff ^ cin_c;
    cout_c = (a & b_eff) | (a & cin_c) | (b_eff & cin_c);
    ovf_c  = 1'b0;
    if (last) begin
      if (SIGNED_OVF) begin
        ovf_c = cin_c ^ cout_c;
      end else begin
        ovf_c = (sub_q == MODE_SUB) ? ~cout_c : cout_c;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
      sum_o   <= 1'b0;
      ovf_o   <= 1'b0;
    end else if (in_valid) begin
      carry_q <= cout_c;
      sum_o   <= sum_c;
      ovf_o   <= ovf_c;
    end else begin
      ovf_o   <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_adder_multi.sv
// LANES independent bit-serial add/subtract lanes sharing a word counter and mode.
module serial_adder_multi
  import serial_adder_pkg::*;
#(
  parameter int unsigned WORD_LEN   = WORD_LEN_DEF,
  parameter int unsigned LANES      = LANES_DEF,
  parameter bit          SIGNED_OVF = SIGNED_OVF_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             mode_sub,
  input  logic [LANES-1:0] line1,
  input  logic [LANES-1:0] line2,
  output logic [LANES-1:0] outp,
  output logic             out_valid,
  output logic             word_last,
  output logic [LANES-1:0] overflw
);

  localparam int unsigned      CNT_W    = clog2_min1(WORD_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sub_q, sub_d;
  logic             out_valid_q, word_last_q;
  logic             first_c, last_c, sub_eff_c;
  logic [LANES-1:0] b_eff_c;

  // Word position decode and the mode in force for the current bit.
  always_comb begin
    first_c   = (cnt_q == '0);
    last_c    = (cnt_q == CNT_LAST);
    sub_eff_c = first_c ? mode_sub : sub_q;
    b_eff_c   = line2 ^ {LANES{sub_eff_c}};
  end

  always_comb begin
    cnt_d = cnt_q;
    sub_d = sub_q;
    if (in_valid) begin
      cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
      if (first_c) begin
        sub_d = mode_sub;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      sub_q       <= MODE_ADD;
      out_valid_q <= 1'b0;
      word_last_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      out_valid_q <= in_valid;
      word_last_q <= in_valid & last_c;
    end
  end

  assign out_valid = out_valid_q;
  assign word_last = word_last_q;

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    serial_add_lane #(
      .SIGNED_OVF(SIGNED_OVF)
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .in_valid(in_valid),
      .a       (line1[l]),
      .b_eff   (b_eff_c[l]),
      .first   (first_c),
      .last    (last_c),
      .sub_q   (sub_eff_c),
      .sum_o   (outp[l]),
      .ovf_o   (overflw[l])
    );
  end

endmodule

// File: tb/tb_serial_adder_multi.sv
// Bench for serial_adder_multi: word-level arithmetic model, per-cycle compare, literal pins.
module tb_serial_adder_multi;

  logic       clk = 1'b0;
  logic       reset, in_valid, mode_sub;
  logic [1:0] line1, line2;
  logic [1:0] u_outp, u_ovf, s_outp, s_ovf;
  logic       u_ov, u_wl, s_ov, s_wl;
  logic       c_valid, c_sub, c_l1, c_l2;
  logic       c_outp, c_ov, c_wl, c_ovf;

  always #5 clk = ~clk;

  serial_adder_multi #(.WORD_LEN(8), .LANES(2), .SIGNED_OVF(1'b0)) dut_u (
    .clock(clk), .reset(reset), .in_valid(in_valid), .mode_sub(mode_sub),
    .line1(line1), .line2(line2), .outp(u_outp), .out_valid(u_ov),
    .word_last(u_wl), .overflw(u_ovf));

  serial_adder_multi #(.WORD_LEN(8), .LANES(2), .SIGNED_OVF(1'b1)) dut_s (
    .clock(clk), .reset(reset), .in_valid(in_valid), .mode_sub(mode_sub),
    .line1(line1), .line2(line2), .outp(s_outp), .out_valid(s_ov),
    .word_last(s_wl), .overflw(s_ovf));

  serial_adder_multi #(.WORD_LEN(3), .LANES(1), .SIGNED_OVF(1'b0)) dut_c (
    .clock(clk), .reset(reset), .in_valid(c_valid), .mode_sub(c_sub),
    .line1(c_l1), .line2(c_l2), .outp(c_outp), .out_valid(c_ov),
    .word_last(c_wl), .overflw(c_ovf));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0][7:0] r;
    logic [1:0]      ou;
    logic [1:0]      os;
  } word_t;

  word_t exp_q[$];
  word_t hist[$];
  logic [3:0] c_hist[$];

  // Word-level arithmetic: result mod 256, unsigned carry/borrow, signed range overflow.
  function automatic word_t model(input logic [1:0][7:0] a, input logic [1:0][7:0] b,
                                  input logic sub);
    word_t m;
    int ua, ub, sa, sb, ur, sr;
    for (int l = 0; l < 2; l++) begin
      ua = int'(a[l]);
      ub = int'(b[l]);
      sa = $signed(a[l]);
      sb = $signed(b[l]);
      ur = sub ? ua - ub : ua + ub;
      sr = sub ? sa - sb : sa + sb;
      m.r[l]  = 8'(ur);
      m.ou[l] = sub ? (ua < ub) : (ur > 255);
      m.os[l] = (sr > 127) || (sr < -128);
    end
    return m;
  endfunction

  logic exp_valid;
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_valid <= 1'b0;
    else        exp_valid <= in_valid;
  end

  // Per-cycle compare of both 8-bit instances against the model.
  initial begin
    int cnt;
    logic [1:0][7:0] acc_u, acc_s;
    word_t e, cap;
    cnt = 0;
    acc_u = '0;
    acc_s = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cnt = 0;
      end else begin
        check("u_out_valid", 64'(u_ov), 64'(exp_valid));
        check("s_out_valid", 64'(s_ov), 64'(exp_valid));
        check("u_word_last", 64'(u_wl), 64'(exp_valid && cnt == 7));
        check("s_word_last", 64'(s_wl), 64'(exp_valid && cnt == 7));
        if (!(exp_valid && cnt == 7)) begin
          check("u_ovf_quiet", 64'(u_ovf), 64'(0));
          check("s_ovf_quiet", 64'(s_ovf), 64'(0));
        end
        if (exp_valid) begin
          for (int l = 0; l < 2; l++) begin
            acc_u[l][cnt] = u_outp[l];
            acc_s[l][cnt] = s_outp[l];
          end
          if (cnt == 7) begin
            if (exp_q.size() == 0) begin
              check("model_queue_nonempty", 64'(0), 64'(1));
            end else begin
              e = exp_q.pop_front();
              check("u_word", 64'(acc_u), 64'(e.r));
              check("s_word", 64'(acc_s), 64'(e.r));
              check("u_overflw", 64'(u_ovf), 64'(e.ou));
              check("s_overflw", 64'(s_ovf), 64'(e.os));
            end
            cap.r  = acc_u;
            cap.ou = u_ovf;
            cap.os = s_ovf;
            hist.push_back(cap);
            cnt = 0;
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  // Capture for the 3-bit single-lane instance.
  initial begin
    int ccnt;
    logic [2:0] cacc;
    ccnt = 0;
    cacc = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ccnt = 0;
      end else if (c_ov) begin
        cacc[ccnt] = c_outp;
        check("c_word_last", 64'(c_wl), 64'(ccnt == 2));
        if (ccnt == 2) begin
          c_hist.push_back({c_ovf, cacc});
          ccnt = 0;
        end else begin
          check("c_ovf_quiet", 64'(c_ovf), 64'(0));
          ccnt++;
        end
      end else begin
        check("c_idle_last", 64'({c_wl, c_ovf}), 64'(0));
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [1:0][7:0] a, input logic [1:0][7:0] b,
                           input logic sub, input int stall_at, input int stall_n,
                           input int toggle_at);
    exp_q.push_back(model(a, b, sub));
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      mode_sub = (toggle_at >= 0 && i >= toggle_at) ? ~sub : sub;
      for (int l = 0; l < 2; l++) begin
        line1[l] = a[l][i];
        line2[l] = b[l][i];
      end
      @(posedge clk);
      #1;
      if (i == stall_at) begin
        for (int k = 0; k < stall_n; k++) begin
          in_valid = 1'b0;
          mode_sub = ~sub;
          line1    = 2'($urandom);
          line2    = 2'($urandom);
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic expect_word(input string name, input int back, input logic [7:0] w0,
                             input logic [7:0] w1, input logic [1:0] ovf, input bit sgn);
    word_t c;
    if (hist.size() <= back) begin
      check({name, "_present"}, 64'(0), 64'(1));
    end else begin
      c = hist[hist.size() - 1 - back];
      check({name, "_lane0"}, 64'(c.r[0]), 64'(w0));
      check({name, "_lane1"}, 64'(c.r[1]), 64'(w1));
      check({name, "_ovf"}, 64'(sgn ? c.os : c.ou), 64'(ovf));
    end
  endtask

  task automatic send_c(input logic [2:0] a, input logic [2:0] b, input logic sub);
    for (int i = 0; i < 3; i++) begin
      c_valid = 1'b1;
      c_sub   = (i == 0) ? sub : ~sub;
      c_l1    = a[i];
      c_l2    = b[i];
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; mode_sub = 1'b0; line1 = '0; line2 = '0;
    c_valid = 1'b0; c_sub = 1'b0; c_l1 = 1'b0; c_l2 = 1'b0;
    #3;
    check("reset_outp",      64'({u_outp, s_outp}), 64'(0));
    check("reset_flags",     64'({u_ov, u_wl, s_ov, s_wl}), 64'(0));
    check("reset_overflw",   64'({u_ovf, s_ovf}), 64'(0));
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned add: 200+100 and 3+4.
    send_word({8'd3, 8'd200}, {8'd4, 8'd100}, 1'b0, -1, 0, -1);
    idle(2);
    expect_word("add_u", 0, 8'h2C, 8'h07, 2'b01, 1'b0);

    // Unsigned sub with mode toggled from bit 3 on.
    send_word({8'd9, 8'd5}, {8'd4, 8'd7}, 1'b1, -1, 0, 3);
    idle(2);
    expect_word("sub_u", 0, 8'hFE, 8'h05, 2'b01, 1'b0);

    // Signed add: 100+50, -3+2.
    send_word({8'hFD, 8'd100}, {8'h02, 8'd50}, 1'b0, -1, 0, -1);
    idle(2);
    expect_word("add_s", 0, 8'h96, 8'hFF, 2'b01, 1'b1);

    // Signed sub: -128-1, 0x10-0x20.
    send_word({8'h10, 8'h80}, {8'h20, 8'h01}, 1'b1, -1, 0, -1);
    idle(2);
    expect_word("sub_s", 0, 8'h7F, 8'hF0, 2'b01, 1'b1);
    expect_word("sub_s_u", 0, 8'h7F, 8'hF0, 2'b10, 1'b0);

    // Three-cycle stall between bits 4 and 5.
    send_word({8'd3, 8'd200}, {8'd4, 8'd100}, 1'b0, 4, 3, -1);
    idle(2);
    expect_word("stall", 0, 8'h2C, 8'h07, 2'b01, 1'b0);

    // Asynchronous reset after bit 3 of a partial word.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      mode_sub = 1'b1;
      line1    = 2'b11;
      line2    = 2'b11;
      @(posedge clk);
      #1;
    end
    #2 reset = 1'b0;
    #1;
    check("midreset_outp",    64'({u_outp, s_outp}), 64'(0));
    check("midreset_flags",   64'({u_ov, u_wl, s_ov, s_wl}), 64'(0));
    check("midreset_overflw", 64'({u_ovf, s_ovf}), 64'(0));
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    send_word({8'd1, 8'd1}, {8'd1, 8'd1}, 1'b0, -1, 0, -1);
    idle(2);
    expect_word("post_reset", 0, 8'h02, 8'h02, 2'b00, 1'b0);

    // Back-to-back words with no gap.
    send_word({8'd255, 8'd255}, {8'd1, 8'd1}, 1'b0, -1, 0, -1);
    send_word({8'd1, 8'd1}, {8'd1, 8'd1}, 1'b0, -1, 0, -1);
    idle(2);
    expect_word("b2b_first", 1, 8'h00, 8'h00, 2'b11, 1'b0);
    expect_word("b2b_second", 0, 8'h02, 8'h02, 2'b00, 1'b0);

    // 3-bit single-lane corner build: 7+1, 3+2, 2-3 back to back.
    send_c(3'd7, 3'd1, 1'b0);
    send_c(3'd3, 3'd2, 1'b0);
    send_c(3'd2, 3'd3, 1'b1);
    c_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("c_words", 64'(c_hist.size()), 64'(3));
    if (c_hist.size() == 3) begin
      check("c_word0", 64'(c_hist[0]), 64'({1'b1, 3'd0}));
      check("c_word1", 64'(c_hist[1]), 64'({1'b0, 3'd5}));
      check("c_word2", 64'(c_hist[2]), 64'({1'b1, 3'd7}));
    end
    check("model_queue_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_multi.md
Name: serial_adder_multi

Overview:
- Parametrised successor to the single-lane serial-flow adder/FSM benchmark block.
- Adds LANES independent bit-serial operand pairs, LSB first, over words of WORD_LEN bits.
- Supports add/subtract per word, unsigned or signed overflow detection, and an input-valid stall.
- Sits as a datapath benchmark block in the ITC99-style test suite.
- Synthesises to the same standard-cell netlist flow.

Parameters:
- WORD_LEN, 8, bits per serial word; legal range 2..64.
- LANES, 2, independent adder lanes; legal range 1..16.
- SIGNED_OVF, 0, 0 = unsigned overflow (carry/borrow); 1 = two's-complement overflow.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  current bit on line1/line2 is valid; low = stall.
- mode_sub  in  1  0 = line1+line2, 1 = line1-line2; sampled only on the first bit of a word.
- line1  in  LANES  serial operand A bit per lane, LSB first.
- line2  in  LANES  serial operand B bit per lane, LSB first.
- outp  out  LANES  registered serial sum/difference bit per lane.
- out_valid  out  1  outp holds a valid bit.
- word_last  out  1  outp is the MSB of a word.
- overflw  out  LANES  per-lane overflow; valid only when word_last=1, else 0.

Behaviour:
- Reset (reset=0, asynchronous): outp=0, out_valid=0, word_last=0, overflw=0, bit counter=0, carries=0, latched mode=0. All regs clear immediately, mid-word included. The next valid bit after reset release is bit 0 of a new word.
- Bit counter:
  - Width is $clog2(WORD_LEN).
  - Increments on each clock with in_valid=1.
  - At WORD_LEN-1 it wraps to 0 on the next valid bit.
  - Holds while in_valid=0.
- Word start (counter=0, in_valid=1):
  - mode_sub is latched into sub_q for the whole word.
  - Effective B = line2 XOR mode_sub.
  - Carry-in = mode_sub, not the stored carry.
- Other bits: effective B = line2 XOR sub_q; carry-in = stored lane carry.
- Per lane, each valid cycle:
  - s = a ^ b ^ cin.
  - cout = majority(a, b, cin).
  - Carry register <= cout.
  - outp <= s.
- Latency: exactly 1 cycle. out_valid <= in_valid. word_last <= (in_valid && counter==WORD_LEN-1).
- Overflow, on the MSB cycle only, registered alongside the MSB sum bit:
  - SIGNED_OVF=0, add: overflw = cout.
  - SIGNED_OVF=0, sub: overflw = ~cout (borrow).
  - SIGNED_OVF=1: overflw = cin ^ cout at the MSB.
  - Any non-MSB or stall cycle: overflw = 0.
- Stall: in_valid=0 leaves counter, carries and sub_q unchanged. out_valid=0, word_last=0, overflw=0. outp holds its last value (don't-care).
- mode_sub changes mid-word have no effect on the current word.
- Lanes share counter, mode and valid; lanes never interact through carries.
- No combinational input-to-output path.

Decomposition:
- Package serial_adder_pkg:
  - function clog2_min1(n) returns max(1, $clog2(n)).
  - localparam defaults.
  - Mode constants MODE_ADD=0, MODE_SUB=1.
- Sub-module serial_add_lane (one instance per lane via generate):
  - Inputs: a, b_eff, first, last, in_valid, sub_q, clock, reset.
  - Holds the carry flop plus the outp/overflw flops.
- Top level holds the counter, sub_q, out_valid and word_last.

Test Plan (WORD_LEN=8, LANES=2 unless stated):
- Unsigned add, lane0 200+100, lane1 3+4, 8 contiguous valid bits → lane0 bits = 0x2C (44), overflw[0]=1 on word_last; lane1 = 0x07, overflw[1]=0; word_last pulses exactly on the 8th output cycle.
- Unsigned sub, mode_sub=1 at bit 0, lane0 5-7, lane1 9-4 → lane0 = 0xFE with overflw=1 (borrow); lane1 = 0x05 with overflw=0. Toggling mode_sub at bit 3 changes nothing.
- SIGNED_OVF=1: lane0 100+50 → 0x96 with overflw=1; lane1 -3+2 (0xFD+0x02) → 0xFF with overflw=0; lane0 sub -128-1 → 0x7F with overflw=1.
- Stall: in_valid low for 3 cycles between bits 4 and 5 of 200+100 → identical result 0x2C/overflw=1; out_valid low on exactly those 3 cycles.
- Reset mid-word: assert reset=0 asynchronously (between edges) after bit 3 → all outputs 0 immediately. After release, a fresh 1+1 word yields 0x02 with overflw=0 and no carry leakage.
- Back-to-back words: 255+1 then 1+1 with no gap → 0x00 with overflw=1, then 0x02 with overflw=0; counter wraps cleanly; WORD_LEN=3 and LANES=1 corner builds also pass.
